// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, GF(2^8) helpers, round constants and the
// controller state encoding.
package aes_pkg;

  localparam int AES128_NR = 10;
  localparam int AES128_NK = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_ctrl_state_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse is x^254 (x^2 * x^4 * ... * x^128), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round plus one AES-128 key-expansion step.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  input  logic         final_round,
  output logic [127:0] st_n,
  output logic [127:0] rk_n
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;
  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7, t;

  // Byte i sits at row i%4, column i/4; byte 0 is the most significant byte.
  always_comb begin
    sr_flat = '0;
    mc_flat = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc_flat[127-32*c -: 8]  = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^
                                sr[4*c+2] ^ sr[4*c+3];
      mc_flat[119-32*c -: 8]  = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^
                                sr[4*c+2] ^ sr[4*c+3];
      mc_flat[111-32*c -: 8]  = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^
                                xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc_flat[103-32*c -: 8]  = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^
                                sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) sr_flat[127-8*i -: 8] = sr[i];
  end

  assign {w0, w1, w2, w3} = rk;
  assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
              {rcon, 24'h000000};
  assign w4 = w0 ^ t;
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign rk_n = {w4, w5, w6, w7};
  assign st_n = (final_round ? sr_flat : mc_flat) ^ rk_n;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock over a shared round datapath.
// Optional AES_CTRL_ABORT_EN adds an abort input that drops the in-flight block.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy,
  output logic [3:0]   round_idx
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  if (NR != AES128_NR || NK != AES128_NK) begin : g_bad_param
    $error("aes_round_ctrl supports only AES-128 (NR=10, NK=4)");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  logic abort_w;
`ifdef AES_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  aes_ctrl_state_t state_q, state_d;
  logic [127:0]    st_q, st_d, rk_q, rk_d, out_data_q, out_data_d;
  logic [127:0]    st_n, rk_n;
  logic [3:0]      round_q, round_d, rcon_idx;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      rcon;

  assign rcon_idx = round_q - 4'd1;
  assign rcon     = (round_q >= 4'd1 && round_q <= 4'd10) ? RCON[rcon_idx] : 8'h00;

  aes_round u_round (
    .st          (st_q),
    .rk          (rk_q),
    .rcon        (rcon),
    .final_round (round_q == LAST_ROUND),
    .st_n        (st_n),
    .rk_n        (rk_n)
  );

  assign in_ready = (state_q == IDLE) && !rst && !abort_w;

  always_comb begin
    // NOTE: every _d takes its held value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (abort_w && state_q != IDLE) begin
      state_d     = IDLE;
      round_d     = 4'd0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid && in_ready) begin
          st_d    = in_data ^ in_key;
          rk_d    = in_key;
          round_d = 4'd1;
          state_d = ROUND;
        end
        ROUND: begin
          rk_d    = rk_n;
          round_d = round_q + 4'd1;
          if (round_q == LAST_ROUND) begin
            out_data_d  = st_n;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            st_d = st_n;
          end
        end
        DONE: if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          round_d     = 4'd0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples the pre-edge values together.
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      round_q     <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign round_idx = round_q;

endmodule
